// File: rtl/spm_mem_pkg.sv
// spm_mem_pkg: shared types and constants for the SPM memory controller.
//
// Contents:
//   state_e        controller states: IDLE, CLEAR, WAIT, ACCESS, RESP
//   WAIT_CNT_W     width of the wait-state counter (max 15 wait states)
//   DEF_WORD_SIZE  default data width
//   DEF_ADDR_W     default address width
//
// Optional feature macro used by the including RTL: SPM_MEM_CLEAR_EN.
package spm_mem_pkg;

    localparam int WAIT_CNT_W    = 4;
    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_ADDR_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/spm_mem_array.sv
// spm_mem_array: DEPTH x WORD_SIZE word storage for the SPM memory controller.
//
// Ports:
//   clk      in   rising-edge clock for the write port
//   we_i     in   write enable
//   waddr_i  in   write address (ADDR_W bits)
//   wdata_i  in   write data (WORD_SIZE bits)
//   raddr_i  in   read address (ADDR_W bits)
//   rdata_o  out  asynchronous read data, 0 for addresses >= DEPTH
//
// The storage has no reset; contents are undefined until written.
// Addresses at or beyond DEPTH never touch the array.
module spm_mem_array
    import spm_mem_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [WORD_SIZE-1:0] rdata_o
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    // Synchronous write port, guarded so that unimplemented addresses are dropped.
    always_ff @(posedge clk) begin
        if (we_i && ({1'b0, waddr_i} < DEPTH_L)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read port; unimplemented addresses read as zero.
    assign rdata_o = ({1'b0, raddr_i} < DEPTH_L) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/spm_mem_ctrl.sv
// spm_mem_ctrl: word-addressed RAM behind a req/ready/ack handshake, with
// programmable wait states, registered read data and out-of-range errors.
//
// Ports:
//   clk     in   clock, all state on the rising edge
//   rst_n   in   asynchronous active-low reset
//   req     in   access request, accepted when ready=1
//   we      in   1=write, 0=read, sampled at accept
//   addr    in   word address, sampled at accept
//   wdata   in   write data, sampled at accept
//   ready   out  controller idle and able to accept
//   ack     out  one-cycle completion pulse
//   err     out  valid with ack: latched addr >= DEPTH
//   rdata   out  read result, held until the next completed read
//   busy    out  inverse of ready
//
// Configuration macro: SPM_MEM_CLEAR_EN. When defined, the controller sweeps
// zeros into every implemented word after reset before becoming ready.
module spm_mem_ctrl
    import spm_mem_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic                 ready,
    output logic                 ack,
    output logic                 err,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 busy
);

    // Elaboration-time parameter sanity checks.
    if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : gen_bad_wait
        $error("spm_mem_ctrl: WAIT_STATES must be in 0..15");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : gen_bad_depth
        $error("spm_mem_ctrl: DEPTH must be in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W:0]         DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0]   WAIT_LAST = WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

`ifdef SPM_MEM_CLEAR_EN
    localparam state_e                  RESET_STATE = ST_CLEAR;
    localparam logic                    RESET_READY = 1'b0;
    localparam logic [ADDR_W-1:0]       LAST_ADDR   = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0]                  clrAddr_q;
`else
    localparam state_e                  RESET_STATE = ST_IDLE;
    localparam logic                    RESET_READY = 1'b1;
`endif

    state_e                  state_q;
    logic [WAIT_CNT_W-1:0]   waitCnt_q;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [WORD_SIZE-1:0]    wdata_q;
    logic [WORD_SIZE-1:0]    rdata_q;
    logic                    ready_q;
    logic                    ack_q;
    logic                    err_q;

    logic                    inRange;
    logic                    arrWe_d;
    logic [ADDR_W-1:0]       arrAddr_d;
    logic [WORD_SIZE-1:0]    arrWdata_d;
    logic [WORD_SIZE-1:0]    arrRdata;

    // Range check is done on the latched address, so late input changes cannot affect it.
    assign inRange = ({1'b0, addr_q} < DEPTH_L);

    // Write-port mux: the clear sweep owns the port while it runs, otherwise
    // only an in-range write in ACCESS commits to the array.
    always_comb begin
        arrWe_d    = (state_q == ST_ACCESS) && we_q && inRange;
        arrAddr_d  = addr_q;
        arrWdata_d = wdata_q;
`ifdef SPM_MEM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            arrWe_d    = 1'b1;
            arrAddr_d  = clrAddr_q;
            arrWdata_d = '0;
        end
`endif
    end

    spm_mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arrWe_d),
        .waddr_i (arrAddr_d),
        .wdata_i (arrWdata_d),
        .raddr_i (addr_q),
        .rdata_o (arrRdata)
    );

    // Controller FSM with registered outputs. ready drops on accept and comes
    // back as RESP exits, so it is high exactly while the state is IDLE.
    // ack/err default low and are set only on the ACCESS -> RESP transition,
    // giving a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            waitCnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= RESET_READY;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef SPM_MEM_CLEAR_EN
            clrAddr_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q      <= we;
                        addr_q    <= addr;
                        wdata_q   <= wdata;
                        ready_q   <= 1'b0;
                        waitCnt_q <= '0;
                        state_q   <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (waitCnt_q == WAIT_LAST) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // Writes leave rdata alone; out-of-range reads return zero.
                    if (!we_q) begin
                        rdata_q <= inRange ? arrRdata : '0;
                    end
                    ack_q   <= 1'b1;
                    err_q   <= !inRange;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
`ifdef SPM_MEM_CLEAR_EN
                ST_CLEAR: begin
                    if (clrAddr_q == LAST_ADDR) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        clrAddr_q <= clrAddr_q + 1'b1;
                    end
                end
`endif
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = ~ready_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule
